stopwatch_chain: RTL

Parametrised cascaded time counter that supersedes the single-register button counter in the timer datapath. It holds ms/sec/min/hr fields simultaneously with per-field modulus and carry propagation. It advances by a selectable step (+1 or +10 ms) on an internal prescaled tick, supports freeze-frame display (hold/lap) and synchronous clear, and outputs all fields plus a unit-selected view for the display mux.

---
 rtl/stopwatch_pkg.sv | 30 +++
 rtl/stopwatch_chain_if.sv | 45 ++++
 rtl/mod_field.sv | 78 +++++++
 rtl/stopwatch_chain.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg -- shared constants for the stopwatch_chain slice.
//   * default field moduli (ms/sec/min/hr)
//   * step_sel encodings and the helper that turns them into a ms amount
//   * unit_sel encodings used by the display mux
package stopwatch_pkg;

  localparam int MS_MOD_DEF  = 1000;
  localparam int SEC_MOD_DEF = 60;
  localparam int MIN_MOD_DEF = 60;
  localparam int HR_MOD_DEF  = 24;

  localparam logic [1:0] STEP_NONE = 2'b00;
  localparam logic [1:0] STEP_1    = 2'b01;
  localparam logic [1:0] STEP_10   = 2'b10;

  localparam logic [1:0] UNIT_MS  = 2'b00;
  localparam logic [1:0] UNIT_SEC = 2'b01;
  localparam logic [1:0] UNIT_MIN = 2'b10;
  localparam logic [1:0] UNIT_HR  = 2'b11;

  // ms added per tick; 2'b11 is treated like STEP_NONE.
  function automatic logic [3:0] step_amount(input logic [1:0] sel);
    case (sel)
      STEP_1:  step_amount = 4'd1;
      STEP_10: step_amount = 4'd10;
      default: step_amount = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_chain_if.sv
// stopwatch_chain_if -- control and display bundle of stopwatch_chain.
//   master: drives run/step_sel/clear/hold/unit_sel, reads the displayed fields
//   slave : the stopwatch itself
// Optional macro COUNT_DOWN_EN adds dir (1 = count down) and the sticky expired flag.
interface stopwatch_chain_if #(
  parameter int MS_W  = 10,
  parameter int SEC_W = 6,
  parameter int MIN_W = 6,
  parameter int HR_W  = 5
);
  logic             run;
  logic [1:0]       step_sel;
  logic             clear;
  logic             hold;
  logic [1:0]       unit_sel;
  logic [MS_W-1:0]  ms_out;
  logic [SEC_W-1:0] sec_out;
  logic [MIN_W-1:0] min_out;
  logic [HR_W-1:0]  hr_out;
  logic [MS_W-1:0]  sel_out;
  logic             rollover;
`ifdef COUNT_DOWN_EN
  logic             dir;
  logic             expired;
`endif

  modport master (
    output run, step_sel, clear, hold, unit_sel,
`ifdef COUNT_DOWN_EN
    output dir,
    input  expired,
`endif
    input  ms_out, sec_out, min_out, hr_out, sel_out, rollover
  );

  modport slave (
    input  run, step_sel, clear, hold, unit_sel,
`ifdef COUNT_DOWN_EN
    input  dir,
    output expired,
`endif
    output ms_out, sec_out, min_out, hr_out, sel_out, rollover
  );

endinterface

// File: rtl/mod_field.sv
// mod_field -- one modulo-MOD counter field of the stopwatch cascade.
//   clk, reset (sync, active-low), clr_i (sync zero)
//   inc_i       : amount added this cycle (step for ms, tied 0 elsewhere)
//   carry_in_i  : +1 from the field below
//   value_o     : registered field value
//   carry_out_o : combinational, this field wraps at the coming edge
// With COUNT_DOWN_EN: dir_i selects subtraction, borrow_in_i/borrow_out_o
// chain the borrow, next_o exposes the pre-clear next value for expiry detection.
module mod_field
  import stopwatch_pkg::*;
#(
  parameter int MOD = 60,
  parameter int IW  = 1,
  parameter int W   = $clog2(MOD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic [IW-1:0] inc_i,
  input  logic          carry_in_i,
`ifdef COUNT_DOWN_EN
  input  logic          dir_i,
  input  logic          borrow_in_i,
  output logic          borrow_out_o,
  output logic [W-1:0]  next_o,
`endif
  output logic [W-1:0]  value_o,
  output logic          carry_out_o
);

  // One extra bit so value + step cannot overflow before the modulus compare.
  localparam int SW = W + 1;

  logic [W-1:0]  value_q, value_d, nxt;
  logic [SW-1:0] sum;
  logic          carry;
`ifdef COUNT_DOWN_EN
  logic [SW-1:0] need;
  logic          borrow;
`endif

  always_comb begin
    sum   = {1'b0, value_q} + SW'(inc_i) + SW'(carry_in_i);
    carry = 1'b0;
    nxt   = W'(sum);
    if (sum >= SW'(MOD)) begin
      carry = 1'b1;
      nxt   = W'(sum - SW'(MOD));
    end
`ifdef COUNT_DOWN_EN
    need   = SW'(inc_i) + SW'(borrow_in_i);
    borrow = 1'b0;
    if (dir_i) begin
      carry = 1'b0;
      if ({1'b0, value_q} >= need) begin
        nxt = W'({1'b0, value_q} - need);
      end else begin
        nxt    = W'({1'b0, value_q} + SW'(MOD) - need);
        borrow = 1'b1;
      end
    end
`endif
    value_d = clr_i ? '0 : nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value_o     = value_q;
  assign carry_out_o = carry;
`ifdef COUNT_DOWN_EN
  assign borrow_out_o = borrow;
  assign next_o       = nxt;
`endif

endmodule

// File: rtl/stopwatch_chain.sv
// stopwatch_chain -- cascaded ms/sec/min/hr stopwatch with prescaled tick.
//   clk, reset (sync, active-low)
//   bus (stopwatch_chain_if.slave): run, step_sel, clear, hold, unit_sel in;
//     ms/sec/min/hr_out (held display), sel_out (unit view), rollover pulse out.
// Optional macro COUNT_DOWN_EN: bus.dir counts down, bus.expired goes sticky
// when the count reaches or would pass zero; further ticks are then ignored.
module stopwatch_chain
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int MS_MOD   = MS_MOD_DEF,
  parameter int SEC_MOD  = SEC_MOD_DEF,
  parameter int MIN_MOD  = MIN_MOD_DEF,
  parameter int HR_MOD   = HR_MOD_DEF
) (
  input logic              clk,
  input logic              reset,
  stopwatch_chain_if.slave bus
);

  localparam int PW    = $clog2(TICK_DIV);
  localparam int MS_W  = $clog2(MS_MOD);
  localparam int SEC_W = $clog2(SEC_MOD);
  localparam int MIN_W = $clog2(MIN_MOD);
  localparam int HR_W  = $clog2(HR_MOD);

  logic [PW-1:0]    presc_q, presc_d;
  logic [MS_W-1:0]  disp_ms_q, disp_ms_d;
  logic [SEC_W-1:0] disp_sec_q, disp_sec_d;
  logic [MIN_W-1:0] disp_min_q, disp_min_d;
  logic [HR_W-1:0]  disp_hr_q, disp_hr_d;
  logic             rollover_q, rollover_d;

  logic [MS_W-1:0]  ms_val;
  logic [SEC_W-1:0] sec_val;
  logic [MIN_W-1:0] min_val;
  logic [HR_W-1:0]  hr_val;
  logic             ms_c, sec_c, min_c, hr_c;
  logic             tick, adv, field_clr;
  logic [3:0]       step_amt, ms_inc;

  assign tick     = bus.run && (presc_q == PW'(TICK_DIV - 1));
  assign step_amt = step_amount(bus.step_sel);

`ifdef COUNT_DOWN_EN
  logic             expired_q, expired_d, expire_now;
  logic             ms_b, sec_b, min_b, hr_b;
  logic [MS_W-1:0]  ms_nxt;
  logic [SEC_W-1:0] sec_nxt;
  logic [MIN_W-1:0] min_nxt;
  logic [HR_W-1:0]  hr_nxt;

  // A tick that lands on zero or underflows terminates the countdown.
  assign adv        = tick && !bus.clear && (step_amt != 4'd0) && !expired_q;
  assign expire_now = adv && bus.dir &&
                      (hr_b || (ms_nxt == '0 && sec_nxt == '0 && min_nxt == '0 && hr_nxt == '0));
  assign field_clr  = bus.clear || expire_now;
  assign expired_d  = bus.clear ? 1'b0 : (expired_q || expire_now);
  assign bus.expired = expired_q;
`else
  assign adv       = tick && !bus.clear && (step_amt != 4'd0);
  assign field_clr = bus.clear;
`endif

  // Only the ms field sees the step; carries ripple combinationally upward.
  assign ms_inc = adv ? step_amt : 4'd0;

  mod_field #(.MOD(MS_MOD), .IW(4)) u_ms (
    .clk(clk), .reset(reset), .clr_i(field_clr), .inc_i(ms_inc), .carry_in_i(1'b0),
`ifdef COUNT_DOWN_EN
    .dir_i(bus.dir), .borrow_in_i(1'b0), .borrow_out_o(ms_b), .next_o(ms_nxt),
`endif
    .value_o(ms_val), .carry_out_o(ms_c)
  );

  mod_field #(.MOD(SEC_MOD), .IW(1)) u_sec (
    .clk(clk), .reset(reset), .clr_i(field_clr), .inc_i(1'b0), .carry_in_i(ms_c),
`ifdef COUNT_DOWN_EN
    .dir_i(bus.dir), .borrow_in_i(ms_b), .borrow_out_o(sec_b), .next_o(sec_nxt),
`endif
    .value_o(sec_val), .carry_out_o(sec_c)
  );

  mod_field #(.MOD(MIN_MOD), .IW(1)) u_min (
    .clk(clk), .reset(reset), .clr_i(field_clr), .inc_i(1'b0), .carry_in_i(sec_c),
`ifdef COUNT_DOWN_EN
    .dir_i(bus.dir), .borrow_in_i(sec_b), .borrow_out_o(min_b), .next_o(min_nxt),
`endif
    .value_o(min_val), .carry_out_o(min_c)
  );

  mod_field #(.MOD(HR_MOD), .IW(1)) u_hr (
    .clk(clk), .reset(reset), .clr_i(field_clr), .inc_i(1'b0), .carry_in_i(min_c),
`ifdef COUNT_DOWN_EN
    .dir_i(bus.dir), .borrow_in_i(min_b), .borrow_out_o(hr_b), .next_o(hr_nxt),
`endif
    .value_o(hr_val), .carry_out_o(hr_c)
  );

  always_comb begin
    presc_d    = presc_q;
    disp_ms_d  = disp_ms_q;
    disp_sec_d = disp_sec_q;
    disp_min_d = disp_min_q;
    disp_hr_d  = disp_hr_q;
    if (bus.clear) begin
      presc_d = '0;
    end else if (bus.run) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    // Display trails the internal fields by one cycle unless frozen by hold.
    if (bus.clear) begin
      disp_ms_d  = '0;
      disp_sec_d = '0;
      disp_min_d = '0;
      disp_hr_d  = '0;
    end else if (!bus.hold) begin
      disp_ms_d  = ms_val;
      disp_sec_d = sec_val;
      disp_min_d = min_val;
      disp_hr_d  = hr_val;
    end
    // hr carry only exists in up mode, so down counting never pulses this.
    rollover_d = adv && hr_c;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q    <= '0;
      disp_ms_q  <= '0;
      disp_sec_q <= '0;
      disp_min_q <= '0;
      disp_hr_q  <= '0;
      rollover_q <= 1'b0;
`ifdef COUNT_DOWN_EN
      expired_q  <= 1'b0;
`endif
    end else begin
      presc_q    <= presc_d;
      disp_ms_q  <= disp_ms_d;
      disp_sec_q <= disp_sec_d;
      disp_min_q <= disp_min_d;
      disp_hr_q  <= disp_hr_d;
      rollover_q <= rollover_d;
`ifdef COUNT_DOWN_EN
      expired_q  <= expired_d;
`endif
    end
  end

  always_comb begin
    case (bus.unit_sel)
      UNIT_SEC: bus.sel_out = MS_W'(disp_sec_q);
      UNIT_MIN: bus.sel_out = MS_W'(disp_min_q);
      UNIT_HR:  bus.sel_out = MS_W'(disp_hr_q);
      default:  bus.sel_out = disp_ms_q;
    endcase
  end

  assign bus.ms_out   = disp_ms_q;
  assign bus.sec_out  = disp_sec_q;
  assign bus.min_out  = disp_min_q;
  assign bus.hr_out   = disp_hr_q;
  assign bus.rollover = rollover_q;

endmodule
